// File: rtl/nbk_chain_decoder.sv
// Pipelined decoder for the +1 increment chain: recovers a = e - 4 from {b,c,d,e}
// over four register stages and flags any tuple not consistent with e.
module nbk_chain_decoder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [WIDTH-1:0] in_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [WIDTH-1:0] dec1(input logic [WIDTH-1:0] x);
    return x - WIDTH'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  logic             vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic             vld_p1_d, vld_p2_d, vld_p3_d, vld_p4_d;
  logic [WIDTH-1:0] v_p1_q, v_p2_q, v_p3_q, v_p4_q;
  logic [WIDTH-1:0] v_p1_d, v_p2_d, v_p3_d, v_p4_d;
  logic             err_p1_q, err_p2_q, err_p3_q, err_p4_q;
  logic             err_p1_d, err_p2_d, err_p3_d, err_p4_d;
  logic [WIDTH-1:0] c_p1_q, b_p1_q, b_p2_q;
  logic [WIDTH-1:0] c_p1_d, b_p1_d, b_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en1, en2, en3, en4;
  logic             ld1, ld2, ld3, ld4;
  logic             hs_out;

  // Ready ripples combinationally from the sink back to the input.
  assign hs_out = vld_p4_q & out_ready;
  assign en4    = ~vld_p4_q | out_ready;
  assign en3    = ~vld_p3_q | en4;
  assign en2    = ~vld_p2_q | en3;
  assign en1    = ~vld_p1_q | en2;
  assign ld1    = in_valid & en1;
  assign ld2    = vld_p1_q & en2;
  assign ld3    = vld_p2_q & en3;
  assign ld4    = vld_p3_q & en4;

  always_comb begin
    vld_p1_d = en1 ? in_valid : vld_p1_q;
    vld_p2_d = en2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = en3 ? vld_p2_q : vld_p3_q;
    vld_p4_d = en4 ? vld_p3_q : vld_p4_q;
    v_p1_d   = v_p1_q;
    v_p2_d   = v_p2_q;
    v_p3_d   = v_p3_q;
    v_p4_d   = v_p4_q;
    err_p1_d = err_p1_q;
    err_p2_d = err_p2_q;
    err_p3_d = err_p3_q;
    err_p4_d = err_p4_q;
    c_p1_d   = c_p1_q;
    b_p1_d   = b_p1_q;
    b_p2_d   = b_p2_q;
    cnt_d    = cnt_q;
    // S1: derive d from e
    if (ld1) begin
      v_p1_d   = dec1(in_e);
      err_p1_d = (dec1(in_e) != in_d);
      c_p1_d   = in_c;
      b_p1_d   = in_b;
    end
    // S2: derive c
    if (ld2) begin
      v_p2_d   = dec1(v_p1_q);
      err_p2_d = err_p1_q | (dec1(v_p1_q) != c_p1_q);
      b_p2_d   = b_p1_q;
    end
    // S3: derive b
    if (ld3) begin
      v_p3_d   = dec1(v_p2_q);
      err_p3_d = err_p2_q | (dec1(v_p2_q) != b_p2_q);
    end
    // S4: derive a
    if (ld4) begin
      v_p4_d   = dec1(v_p3_q);
      err_p4_d = err_p3_q;
    end
    if (hs_out && err_p4_q) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      v_p1_q   <= '0;
      v_p2_q   <= '0;
      v_p3_q   <= '0;
      v_p4_q   <= '0;
      err_p1_q <= 1'b0;
      err_p2_q <= 1'b0;
      err_p3_q <= 1'b0;
      err_p4_q <= 1'b0;
      c_p1_q   <= '0;
      b_p1_q   <= '0;
      b_p2_q   <= '0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      vld_p4_q <= vld_p4_d;
      v_p1_q   <= v_p1_d;
      v_p2_q   <= v_p2_d;
      v_p3_q   <= v_p3_d;
      v_p4_q   <= v_p4_d;
      err_p1_q <= err_p1_d;
      err_p2_q <= err_p2_d;
      err_p3_q <= err_p3_d;
      err_p4_q <= err_p4_d;
      c_p1_q   <= c_p1_d;
      b_p1_q   <= b_p1_d;
      b_p2_q   <= b_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = vld_p4_q;
  assign out_a     = v_p4_q;
  assign out_err   = err_p4_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_nbk_chain_decoder.sv
// Scoreboard bench for nbk_chain_decoder: accepted tuples push expected {a,err}
// from an arithmetic reference; a negedge monitor pops on every output handshake.
module tb_nbk_chain_decoder;
  localparam int W = 3;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_b = '0, in_c = '0, in_d = '0, in_e = '0;
  logic         in_ready, out_valid, out_err;
  logic [W-1:0] out_a;
  logic [7:0]   err_count;
  logic         in_ready2, out_valid2, out_err2;
  logic [W-1:0] out_a2;
  logic [1:0]   err_count2;

  nbk_chain_decoder #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_err(out_err), .err_count(err_count));

  nbk_chain_decoder #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
    .out_valid(out_valid2), .out_ready(out_ready), .out_a(out_a2),
    .out_err(out_err2), .err_count(err_count2));

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] a; logic err; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int cnt_m = 0, cnt2_m = 0;
  bit stall_prev = 1'b0;
  logic [W-1:0] prev_a = '0;
  logic prev_err = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic int mod_sub(int x, int k);
    return ((x - k) % M + M) % M;
  endfunction

  // Reference: a = e-4; tuple is good only if d,c,b are e-1,e-2,e-3.
  function automatic exp_t model(int b, int c, int d, int e);
    exp_t r;
    r.a   = W'(mod_sub(e, 4));
    r.err = (d != mod_sub(e, 1)) || (c != mod_sub(e, 2)) || (b != mod_sub(e, 3));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt_m = 0;
      cnt2_m = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_a", int'(out_a), int'(prev_a));
        chk("stall_err", int'(out_err), int'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", int'(out_valid), 0);
        else begin
          exp_t ex;
          ex = q.pop_front();
          chk("out_a", int'(out_a), int'(ex.a));
          chk("out_err", int'(out_err), int'(ex.err));
          chk("err_count", int'(err_count), cnt_m);
          chk("sat_valid", int'(out_valid2), 1);
          chk("sat_out_a", int'(out_a2), int'(ex.a));
          chk("sat_err_count", int'(err_count2), cnt2_m);
          if (ex.err) begin
            cnt_m  = (cnt_m < 255) ? cnt_m + 1 : 255;
            cnt2_m = (cnt2_m < 3) ? cnt2_m + 1 : 3;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_a = out_a;
      prev_err = out_err;
      if (in_valid && in_ready) q.push_back(model(in_b, in_c, in_d, in_e));
    end
  end

  task automatic set_tuple(input int b, input int c, input int d, input int e);
    in_b = W'(b); in_c = W'(c); in_d = W'(d); in_e = W'(e);
  endtask

  task automatic send(input int b, input int c, input int d, input int e);
    bit acc;
    acc = 1'b0;
    set_tuple(b, c, d, e);
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", int'(acc), 1);
    in_valid = 1'b0;
  endtask

  task automatic send_good(input int e);
    send(mod_sub(e, 3), mod_sub(e, 2), mod_sub(e, 1), e % M);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_a"}, int'(out_a), 0);
    chk({tag, "_out_err"}, int'(out_err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_err_count_sat"}, int'(err_count2), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_in_ready_sat"}, int'(in_ready2), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Nominal with exact latency
    out_ready = 1'b1;
    set_tuple(2, 3, 4, 5);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_n0", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_n1", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_n2", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_n3_valid", int'(out_valid), 1);
    chk("lat_n3_a", int'(out_a), 1);
    chk("lat_n3_err", int'(out_err), 0);
    drain();

    send(0, 1, 2, 3);
    send(5, 6, 7, 0);
    drain();
    chk("wrap_err_count", int'(err_count), 0);

    send(2, 3, 5, 5);
    drain();
    chk("mismatch1_err_count", int'(err_count), 1);
    send(0, 3, 4, 5);
    drain();
    chk("mismatch2_err_count", int'(err_count), 2);

    // Backpressure: fill all four stages, then release
    out_ready = 1'b0;
    for (int e = 4; e < 8; e++) send_good(e);
    set_tuple(5, 6, 7, 0);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_a", int'(out_a), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_good(8);
    send_good(9);
    drain();

    // Reset with tuples in flight
    send(1, 1, 1, 5);
    drain();
    chk("pre_reset_err_count", int'(err_count), 3);
    out_ready = 1'b0;
    send_good(1);
    send(0, 0, 0, 2);
    send_good(3);
    pulse_reset();
    check_idle("midreset");
    repeat (10) @(posedge clk);
    #1;

    // Saturation on the narrow counter
    for (int i = 0; i < 5; i++) begin
      send(i, i, i, i);
      drain();
    end
    chk("sat_final", int'(err_count2), 3);
    chk("wide_final", int'(err_count), 5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int e;
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      e = int'($urandom_range(0, M - 1));
      if ($urandom_range(0, 1) == 1)
        set_tuple(mod_sub(e, 3), mod_sub(e, 2), mod_sub(e, 1), e);
      else
        set_tuple(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                  int'($urandom_range(0, M - 1)), e);
      @(posedge clk);
      #1;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
